// File: rtl/eth_udp_mold_tx.sv
// Ethernet/IPv4/UDP/MoldUDP64 frame builder. It latches a header request, folds the IPv4
// checksum over 10 cycles, then streams header and payload bytes one per cycle to the TX serializer.
module eth_udp_mold_tx #(
  parameter int         MAX_PAYLOAD = 1410,
  parameter logic [7:0] TTL         = 8'h40,
  parameter int         IFG_CYCLES  = 12
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        startValid,
  output logic        startReady,
  input  logic [47:0] dstMac,
  input  logic [47:0] srcMac,
  input  logic [31:0] srcIp,
  input  logic [31:0] dstIp,
  input  logic [15:0] srcPort,
  input  logic [15:0] dstPort,
  input  logic [79:0] sessId,
  input  logic [63:0] seqNum,
  input  logic [15:0] msgCnt,
  input  logic [15:0] payloadLen,
  input  logic        payValid,
  input  logic [7:0]  payData,
  output logic        payReady,
  output logic        dataValid,
  output logic [7:0]  data,
  output logic        dataLast,
  output logic        lenErr,
  output logic        txErr
);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
  localparam logic [15:0] GAP_LAST = 16'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CSUM, HDR, PAY, GAP} state_t;

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [15:0] id_reg, id_next;
  logic [15:0] sum_reg, sum_next;
  logic        underrun_reg, underrun_next;
  logic        ready_reg, ready_next;
  logic        valid_reg, valid_next;
  logic [7:0]  data_reg, data_next;
  logic        last_reg, last_next;
  logic        lenerr_reg, lenerr_next;
  logic        txerr_reg, txerr_next;
  logic        latch_en;
  logic        pay_ready;

  logic [47:0] dst_mac_reg, src_mac_reg;
  logic [31:0] src_ip_reg, dst_ip_reg;
  logic [15:0] src_port_reg, dst_port_reg, msg_cnt_reg, pay_len_reg;
  logic [79:0] sess_id_reg;
  logic [63:0] seq_num_reg;

  logic [15:0] ip_len, udp_len, chk_sum, csum_word, csum_fold;
  logic [16:0] csum_add;
  logic [511:0] hdr_vec;
  logic [7:0]  hdr_byte [64];

  assign ip_len  = pay_len_reg + 16'd48;
  assign udp_len = pay_len_reg + 16'd28;
  assign chk_sum = ~sum_reg;

  // Header words in IPv4 order; the checksum slot itself contributes zero.
  always_comb begin
    csum_word = 16'h0000;
    case (cnt_reg[3:0])
      4'd0:    csum_word = 16'h4500;
      4'd1:    csum_word = ip_len;
      4'd2:    csum_word = id_reg;
      4'd3:    csum_word = 16'h4000;
      4'd4:    csum_word = {TTL, 8'h11};
      4'd6:    csum_word = src_ip_reg[31:16];
      4'd7:    csum_word = src_ip_reg[15:0];
      4'd8:    csum_word = dst_ip_reg[31:16];
      4'd9:    csum_word = dst_ip_reg[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  // A carry out of the 17-bit add leaves at most 0xFFFE in the low half, so one fold suffices.
  assign csum_add  = {1'b0, sum_reg} + {1'b0, csum_word};
  assign csum_fold = csum_add[15:0] + {15'd0, csum_add[16]};

  assign hdr_vec = {dst_mac_reg, src_mac_reg, 16'h0800, 8'h45, 8'h00, ip_len, id_reg,
                    16'h4000, TTL, 8'h11, chk_sum, src_ip_reg, dst_ip_reg, src_port_reg,
                    dst_port_reg, udp_len, 16'h0000, sess_id_reg, seq_num_reg, msg_cnt_reg,
                    16'h0000};

  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_hdr_byte
      assign hdr_byte[gi] = hdr_vec[511 - 8*gi -: 8];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    id_next       = id_reg;
    sum_next      = sum_reg;
    underrun_next = underrun_reg;
    valid_next    = 1'b0;
    data_next     = 8'h00;
    last_next     = 1'b0;
    lenerr_next   = 1'b0;
    txerr_next    = 1'b0;
    latch_en      = 1'b0;
    pay_ready     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (startValid && ready_reg) begin
          if (payloadLen > MAX_LEN) begin
            lenerr_next = 1'b1;
          end else begin
            latch_en      = 1'b1;
            state_next    = CSUM;
            cnt_next      = 16'd0;
            sum_next      = 16'h0000;
            underrun_next = 1'b0;
          end
        end
      end
      CSUM: begin
        sum_next = csum_fold;
        cnt_next = cnt_reg + 16'd1;
        if (cnt_reg == 16'd9) begin
          state_next = HDR;
          cnt_next   = 16'd0;
        end
      end
      HDR: begin
        valid_next = 1'b1;
        data_next  = hdr_byte[cnt_reg[5:0]];
        cnt_next   = cnt_reg + 16'd1;
        if (cnt_reg == 16'd61) begin
          cnt_next = 16'd0;
          if (pay_len_reg == 16'd0) begin
            last_next  = 1'b1;
            txerr_next = underrun_reg;
            id_next    = id_reg + 16'd1;
            state_next = GAP;
          end else begin
            state_next = PAY;
          end
        end
      end
      PAY: begin
        pay_ready     = 1'b1;
        valid_next    = 1'b1;
        data_next     = payValid ? payData : 8'h00;
        underrun_next = underrun_reg | ~payValid;
        cnt_next      = cnt_reg + 16'd1;
        if (cnt_reg == pay_len_reg - 16'd1) begin
          last_next  = 1'b1;
          txerr_next = underrun_reg | ~payValid;
          id_next    = id_reg + 16'd1;
          cnt_next   = 16'd0;
          state_next = GAP;
        end
      end
      GAP: begin
        cnt_next = cnt_reg + 16'd1;
        if (cnt_reg == GAP_LAST) begin
          cnt_next   = 16'd0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    ready_next = (state_next == IDLE);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_reg    <= IDLE;
      cnt_reg      <= 16'd0;
      id_reg       <= 16'h0000;
      sum_reg      <= 16'h0000;
      underrun_reg <= 1'b0;
      ready_reg    <= 1'b0;
      valid_reg    <= 1'b0;
      data_reg     <= 8'h00;
      last_reg     <= 1'b0;
      lenerr_reg   <= 1'b0;
      txerr_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      id_reg       <= id_next;
      sum_reg      <= sum_next;
      underrun_reg <= underrun_next;
      ready_reg    <= ready_next;
      valid_reg    <= valid_next;
      data_reg     <= data_next;
      last_reg     <= last_next;
      lenerr_reg   <= lenerr_next;
      txerr_reg    <= txerr_next;
    end
  end

  // Request fields only matter between acceptance and dataLast, so they carry no reset.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      dst_mac_reg  <= dstMac;
      src_mac_reg  <= srcMac;
      src_ip_reg   <= srcIp;
      dst_ip_reg   <= dstIp;
      src_port_reg <= srcPort;
      dst_port_reg <= dstPort;
      sess_id_reg  <= sessId;
      seq_num_reg  <= seqNum;
      msg_cnt_reg  <= msgCnt;
      pay_len_reg  <= payloadLen;
    end
  end

  assign startReady = ready_reg;
  assign payReady   = pay_ready;
  assign dataValid  = valid_reg;
  assign data       = data_reg;
  assign dataLast   = last_reg;
  assign lenErr     = lenerr_reg;
  assign txErr      = txerr_reg;

endmodule
